// File: rtl/irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl
//   Front end of the interrupt path. Each raw line is synchronised, then
//   either rising-edge latched or level-followed into a pending register.
//   The enable mask gates pending toward the downstream priority encoder.
//   A CPU acknowledge clears the pending and overflow bits of the serviced id.
//
// Ports
//   clk            single clock, all state on rising edge
//   rst            asynchronous, active-high reset
//   irq_in         raw interrupt lines, asynchronous to clk
//   irq_edge_mode  per line: 1 = rising-edge latched, 0 = level
//   irq_mask       per line: 1 = enabled toward the encoder
//   ack_valid      acknowledge strobe, one cycle per ack
//   ack_id         index being acknowledged
//   pending        raw pending register, unmasked
//   irq_req        pending & irq_mask
//   irq_out        OR of irq_req
//   overflow       sticky: edge arrived while the line was already pending
// ----------------------------------------------------------------------------
module irq_pending_ctrl #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned ID_W        = $clog2(NUM_IRQ),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_edge_mode,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ack_valid,
    input  logic [ID_W-1:0]    ack_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] irq_req,
    output logic               irq_out,
    output logic [NUM_IRQ-1:0] overflow
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] overflow_q, overflow_d;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;

    // Out-of-range ack ids match no line and therefore change nothing.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            clr[i] = ack_valid && (32'(ack_id) == i);
        end
    end

    // Edge lines: a new edge wins over a same-cycle ack. Level lines copy the
    // synchronised input and ignore ack for pending; overflow is only held.
    always_comb begin
        pending_d  = (irq_edge_mode & (rise | (pending_q & ~clr))) | (~irq_edge_mode & sync_s);
        overflow_d = ~clr & (overflow_q | (irq_edge_mode & rise & pending_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            prev_q     <= sync_s;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Combinational from registered state only: mask changes show at once,
    // and there is no path from irq_in.
    assign pending  = pending_q;
    assign irq_req  = pending_q & irq_mask;
    assign irq_out  = |irq_req;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in, edge_mode, mask;
    logic       ack_valid;
    logic [2:0] ack_id;
    logic [7:0] pending, irq_req, overflow;
    logic       irq_out;

    logic [5:0] irq_in6, edge_mode6, mask6;
    logic       ack_valid6;
    logic [2:0] ack_id6;
    logic [5:0] pending6, irq_req6, overflow6;
    logic       irq_out6;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    irq_pending_ctrl #(
        .NUM_IRQ     (8),
        .ID_W        (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .irq_edge_mode (edge_mode),
        .irq_mask      (mask),
        .ack_valid     (ack_valid),
        .ack_id        (ack_id),
        .pending       (pending),
        .irq_req       (irq_req),
        .irq_out       (irq_out),
        .overflow      (overflow)
    );

    irq_pending_ctrl #(
        .NUM_IRQ     (6),
        .ID_W        (3),
        .SYNC_STAGES (2)
    ) dut6 (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in6),
        .irq_edge_mode (edge_mode6),
        .irq_mask      (mask6),
        .ack_valid     (ack_valid6),
        .ack_id        (ack_id6),
        .pending       (pending6),
        .irq_req       (irq_req6),
        .irq_out       (irq_out6),
        .overflow      (overflow6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned P  = 0;
    localparam int unsigned RQ = 1;
    localparam int unsigned IO = 2;
    localparam int unsigned OV = 3;
    localparam int unsigned P6 = 4;
    localparam int unsigned O6 = 5;

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            P:       return 32'(pending);
            RQ:      return 32'(irq_req);
            IO:      return 32'(irq_out);
            OV:      return 32'(overflow);
            P6:      return 32'(pending6);
            O6:      return 32'(overflow6);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.exp) else begin
                n_errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack8(input logic [2:0] id);
        ack_valid = 1'b1;
        ack_id    = id;
        step(1);
        ack_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        irq_in     = 8'hFF;
        edge_mode  = 8'hFF;
        mask       = 8'hFF;
        ack_valid  = 1'b0;
        ack_id     = '0;
        irq_in6    = '0;
        edge_mode6 = 6'h3F;
        mask6      = 6'h3F;
        ack_valid6 = 1'b0;
        ack_id6    = '0;

        // Reset with all lines high.
        step(3);
        expect_val("rst_pending", P, 32'h00);
        expect_val("rst_irq_req", RQ, 32'h00);
        expect_val("rst_overflow", OV, 32'h00);
        expect_val("rst_irq_out", IO, 32'h0);
        check();
        irq_in = 8'h00;
        step(1);
        rst = 1'b0;
        step(4);
        expect_val("idle_pending", P, 32'h00);
        check();

        // Edge capture latency on line 5, then ack.
        irq_in = 8'h20;
        step(2);
        expect_val("edge5_early", P, 32'h00);
        check();
        step(1);
        expect_val("edge5_pending", P, 32'h20);
        expect_val("edge5_irq_out", IO, 32'h1);
        expect_val("edge5_irq_req", RQ, 32'h20);
        check();
        ack8(3'd5);
        expect_val("ack5_pending", P, 32'h00);
        expect_val("ack5_irq_out", IO, 32'h0);
        check();

        // Overflow on line 2.
        irq_in = 8'h24;
        step(3);
        expect_val("ov_first_pending", P, 32'h04);
        expect_val("ov_first_overflow", OV, 32'h00);
        check();
        irq_in = 8'h20;
        step(3);
        irq_in = 8'h24;
        step(3);
        expect_val("ov_second_overflow", OV, 32'h04);
        expect_val("ov_second_pending", P, 32'h04);
        check();
        ack8(3'd2);
        expect_val("ov_ack_pending", P, 32'h00);
        expect_val("ov_ack_overflow", OV, 32'h00);
        check();

        // Edge coincident with ack while already pending: set wins, no overflow.
        irq_in = 8'h20;
        step(3);
        irq_in = 8'h24;
        step(3);
        expect_val("coin_pre_pending", P, 32'h04);
        check();
        irq_in = 8'h20;
        step(3);
        irq_in = 8'h24;
        step(2);
        ack8(3'd2);
        expect_val("coin_pending", P, 32'h04);
        expect_val("coin_overflow", OV, 32'h00);
        check();

        // Level mode with mask.
        edge_mode = 8'h00;
        irq_in    = 8'h81;
        mask      = 8'h01;
        step(3);
        expect_val("lvl_pending", P, 32'h81);
        expect_val("lvl_irq_req", RQ, 32'h01);
        expect_val("lvl_irq_out", IO, 32'h1);
        check();
        ack8(3'd0);
        expect_val("lvl_ack_pending", P, 32'h81);
        check();
        irq_in = 8'h80;
        step(2);
        expect_val("lvl_drop_early", P, 32'h81);
        check();
        step(1);
        expect_val("lvl_drop_pending", P, 32'h80);
        expect_val("lvl_drop_irq_req", RQ, 32'h00);
        expect_val("lvl_drop_irq_out", IO, 32'h0);
        check();
        #1 mask = 8'h80;
        #1;
        expect_val("mask_comb_irq_req", RQ, 32'h80);
        expect_val("mask_comb_irq_out", IO, 32'h1);
        check();

        // Build pending=3C, overflow=04 in edge mode.
        step(1);
        edge_mode = 8'hFF;
        mask      = 8'hFF;
        irq_in    = 8'h00;
        ack8(3'd7);
        step(3);
        expect_val("pre_rst_clear", P, 32'h00);
        check();
        irq_in = 8'h3C;
        step(3);
        irq_in = 8'h38;
        step(3);
        irq_in = 8'h3C;
        step(3);
        expect_val("pre_rst_pending", P, 32'h3C);
        expect_val("pre_rst_overflow", OV, 32'h04);
        check();

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        irq_in = 8'h02;
        #1;
        expect_val("arst_pending", P, 32'h00);
        expect_val("arst_irq_req", RQ, 32'h00);
        expect_val("arst_irq_out", IO, 32'h0);
        expect_val("arst_overflow", OV, 32'h00);
        check();
        step(3);
        rst = 1'b0;
        step(2);
        expect_val("rel_early", P, 32'h00);
        check();
        step(1);
        expect_val("rel_pending", P, 32'h02);
        expect_val("rel_overflow", OV, 32'h00);
        check();

        // Six-line instance: out-of-range ack ids are ignored.
        irq_in6 = 6'h21;
        step(3);
        irq_in6 = 6'h20;
        step(3);
        irq_in6 = 6'h21;
        step(3);
        expect_val("n6_pending", P6, 32'h21);
        expect_val("n6_overflow", O6, 32'h01);
        check();
        ack_valid6 = 1'b1;
        ack_id6    = 3'd7;
        step(1);
        ack_id6    = 3'd6;
        step(1);
        ack_valid6 = 1'b0;
        expect_val("n6_illegal_pending", P6, 32'h21);
        expect_val("n6_illegal_overflow", O6, 32'h01);
        check();
        ack_valid6 = 1'b1;
        ack_id6    = 3'd0;
        step(1);
        ack_valid6 = 1'b0;
        expect_val("n6_ack0_pending", P6, 32'h20);
        expect_val("n6_ack0_overflow", O6, 32'h00);
        check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
